// File: rtl/prime_scan_ctrl.sv
// prime_scan_ctrl: sweeps a 4-bit range through the external prime/multiple indicator and counts flag hits.
module prime_scan_ctrl #(
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [3:0]         lo,
  input  logic [3:0]         hi,
  output logic [3:0]         cls_in,
  input  logic               cls_prime,
  input  logic [4:0]         cls_mul,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   prime_cnt,
  output logic [5*CNT_W-1:0] mul_cnt
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] hi_q;
  logic accept, last;
  // A start in DONE is honoured like one in IDLE, which gives back-to-back sweeps.
  assign accept = start && (state != SCAN);
  assign last = cls_in == hi_q;
  always_ff @(posedge clk)
    state <= !reset_n ? IDLE : state_nx;
  always_comb
    state_nx = accept ? SCAN : state == SCAN ? (last ? DONE : SCAN) : IDLE;
  always_comb begin
    busy = state == SCAN;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cls_in    <= '0;
      hi_q      <= '0;
      prime_cnt <= '0;
      mul_cnt   <= '0;
    end else if (accept) begin
      cls_in    <= lo;
      hi_q      <= hi;
      prime_cnt <= '0;
      mul_cnt   <= '0;
    end else if (state == SCAN) begin
      prime_cnt <= prime_cnt + CNT_W'(cls_prime);
      for (int k = 0; k < 5; k++)
        mul_cnt[CNT_W*k +: CNT_W] <= mul_cnt[CNT_W*k +: CNT_W] + CNT_W'(cls_mul[k]);
      if (!last) cls_in <= cls_in + 4'd1;
    end
  end
endmodule
